// File: rtl/banner_blitter.sv
// banner_blitter: copies a 16-row, 48-column scrolled glyph window into a 32-pixel-wide line store
module banner_blitter (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  offset,
    input  logic [4:0]  base_row,
    output logic [3:0]  gx,
    output logic [3:0]  gy,
    input  logic        pixell,
    input  logic        pixelc,
    input  logic        pixelr,
    output logic [4:0]  wr_addr,
    output logic [31:0] wr_data,
    output logic        wr_valid,
    input  logic        wr_ready,
    output logic        busy,
    output logic        done
);
    typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} state_t;
    state_t      r_state;
    logic [5:0]  r_off;
    logic [4:0]  r_base;
    logic [47:0] r_line;
    logic [47:0] w_line;
    logic [95:0] w_dbl;
    logic [31:0] w_rot;
    always_comb begin
        w_line = r_line;
        w_line[{2'b00, gx}] = pixell;
        w_line[{2'b01, gx}] = pixelc;
        w_line[{2'b10, gx}] = pixelr;
        w_dbl = {w_line, w_line} >> r_off;
        for (int j = 0; j < 32; j++) w_rot[31-j] = w_dbl[j];
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_off    <= '0;
            r_base   <= '0;
            r_line   <= '0;
            gx       <= '0;
            gy       <= '0;
            wr_addr  <= '0;
            wr_data  <= '0;
            wr_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_off   <= offset >= 6'd48 ? offset - 6'd48 : offset;
                        r_base  <= base_row;
                        gx      <= '0;
                        gy      <= '0;
                        busy    <= 1'b1;
                        r_state <= FETCH;
                    end
                end
                FETCH: begin
                    r_line <= w_line;
                    gx     <= gx + 4'd1;
                    if (gx == 4'd15) begin
                        wr_data  <= w_rot;
                        wr_addr  <= r_base + {1'b0, gy};
                        wr_valid <= 1'b1;
                        r_state  <= WRITE;
                    end
                end
                WRITE: begin
                    if (wr_ready) begin
                        wr_valid <= 1'b0;
                        if (gy == 4'd15) begin
                            done    <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            gy      <= gy + 4'd1;
                            r_state <= FETCH;
                        end
                    end
                end
                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_banner_blitter.sv
// tb_banner_blitter: directed checks of banner_blitter against a small glyph ROM and window model
module tb_banner_blitter;
    logic        clk = 1'b0;
    logic        reset, start, wr_ready;
    logic [5:0]  offset;
    logic [4:0]  base_row;
    logic [3:0]  gx, gy;
    logic        pixell, pixelc, pixelr;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        wr_valid, busy, done;
    logic [47:0] rom [16];
    logic [4:0]  q_addr [$];
    logic [31:0] q_data [$];
    int          cnt = 0;
    int          acc = 0;
    int          n_tot = 0;
    int          n_bad = 0;
    int          done_cyc = 0;
    bit          done_seen = 1'b0;

    banner_blitter dut (
        .clk(clk), .reset(reset), .start(start), .offset(offset), .base_row(base_row),
        .gx(gx), .gy(gy), .pixell(pixell), .pixelc(pixelc), .pixelr(pixelr),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cnt <= cnt + 1;
    always_comb begin
        pixell = rom[gy][{2'b00, gx}];
        pixelc = rom[gy][{2'b01, gx}];
        pixelr = rom[gy][{2'b10, gx}];
    end
    always @(negedge clk) begin
        if (wr_valid && wr_ready) begin
            q_addr.push_back(wr_addr);
            q_data.push_back(wr_data);
        end
        if (done) begin
            done_seen = 1'b1;
            done_cyc  = cnt - acc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_row(input int row, input int off);
        logic [31:0] d;
        for (int j = 0; j < 32; j++) d[31-j] = rom[row][(off + j) % 48];
        return d;
    endfunction

    task automatic arm();
        acc = cnt - 1;
        done_seen = 1'b0;
        q_addr.delete();
        q_data.delete();
    endtask

    task automatic start_op(input logic [5:0] off, input logic [4:0] base);
        offset = off;
        base_row = base;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        arm();
    endtask

    task automatic goto(input int n);
        repeat (n - (cnt - acc)) @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int lim);
        int k = 0;
        while (!done_seen && k < lim) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (!done_seen) chk("done_timeout", {31'd0, done_seen}, 32'd1);
    endtask

    task automatic check_rows(input string tag, input int base, input int off);
        chk({tag, "_count"}, q_addr.size(), 32'd16);
        for (int i = 0; i < 16 && i < q_addr.size(); i++) begin
            chk({tag, "_addr"}, q_addr[i], (base + i) & 31);
            chk({tag, "_data"}, q_data[i], exp_row(i, off));
        end
    endtask

    initial begin
        logic [31:0] k1 = 32'hFFCF033F;
        rom[0]  = '0;
        rom[15] = '0;
        for (int c = 0; c < 32; c++) rom[1][c] = k1[31-c];
        rom[1][47:32] = 16'hFF03;
        for (int r = 2; r < 15; r++) rom[r] = 48'h9C3A_5E71_B2D4 ^ {12{4'(r)}};
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion earlier");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; offset = '0; base_row = '0; wr_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", wr_valid, 0);
        chk("rst_addr", wr_addr, 0);
        chk("rst_data", wr_data, 0);
        chk("rst_gx", gx, 0);
        chk("rst_gy", gy, 0);

        // offset 0, base 0, with mid-operation input changes and a stray start
        start_op(6'd0, 5'd0);
        goto(5);
        offset = 6'd33; base_row = 5'd9; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("a_busy", busy, 1);
        goto(17);
        @(negedge clk);
        chk("a_valid17", wr_valid, 1);
        goto(18);
        @(negedge clk);
        chk("a_valid18", wr_valid, 0);
        wait_done(400);
        chk("a_done_cyc", done_cyc, 273);
        chk("a_row0", q_data.size() > 0 ? q_data[0] : 32'hDEAD, 32'h00000000);
        chk("a_row1", q_data.size() > 1 ? q_data[1] : 32'hDEAD, 32'hFFCF033F);
        chk("a_row15", q_data.size() > 15 ? q_data[15] : 32'hDEAD, 32'h00000000);
        check_rows("a", 0, 0);
        @(negedge clk);
        chk("a_busy_after", busy, 0);
        chk("a_done_after", done, 0);

        // offset 40 wraps across column 47; start raised during done
        start_op(6'd40, 5'd0);
        goto(273);
        chk("b_row1", q_data.size() > 1 ? q_data[1] : 32'hDEAD, 32'hFFFFCF03);
        check_rows("b", 0, 40);
        start = 1'b1;
        @(negedge clk);
        chk("b_done273", done, 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("b_busy274", busy, 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        arm();
        chk("b_busy275", busy, 1);
        wait_done(400);
        chk("b2_done_cyc", done_cyc, 273);
        check_rows("b2", 0, 40);

        // offset 50 is taken as 2
        start_op(6'd50, 5'd0);
        wait_done(400);
        chk("c_row1", q_data.size() > 1 ? q_data[1] : 32'hDEAD, 32'hFF3C0CFF);
        check_rows("c", 0, 2);

        // base 20 wraps store addresses
        start_op(6'd0, 5'd20);
        wait_done(400);
        chk("d_addr12", q_addr.size() > 12 ? q_addr[12] : 5'd31, 32'd0);
        check_rows("d", 20, 0);

        // store back-pressure during the row-3 write
        start_op(6'd0, 5'd0);
        goto(68);
        wr_ready = 1'b0;
        @(negedge clk);
        chk("e_valid68", wr_valid, 1);
        chk("e_addr68", wr_addr, 3);
        chk("e_data68", wr_data, exp_row(3, 0));
        goto(72);
        @(negedge clk);
        chk("e_valid72", wr_valid, 1);
        chk("e_addr72", wr_addr, 3);
        chk("e_data72", wr_data, exp_row(3, 0));
        goto(73);
        wr_ready = 1'b1;
        wait_done(400);
        chk("e_done_cyc", done_cyc, 278);
        check_rows("e", 0, 0);

        // reset aborts an operation, then a fresh one runs normally
        start_op(6'd0, 5'd0);
        goto(100);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        q_addr.delete();
        q_data.delete();
        @(negedge clk);
        chk("f_busy", busy, 0);
        chk("f_valid", wr_valid, 0);
        chk("f_gx", gx, 0);
        goto(105);
        reset = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0; start = 1'b0;
        chk("f_rst_prio", busy, 0);
        goto(110);
        chk("f_no_writes", q_addr.size(), 0);
        chk("f_busy110", busy, 0);
        start_op(6'd0, 5'd0);
        wait_done(400);
        chk("f_done_cyc", done_cyc, 273);
        chk("f_row1", q_data.size() > 1 ? q_data[1] : 32'hDEAD, 32'hFFCF033F);
        check_rows("f", 0, 0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule

// File: doc/banner_blitter.md
BANNER_BLITTER -- requirements
Module: banner_blitter

Interface
REQ-001 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port start  input  1  request to copy one banner window into the store; sampled only in IDLE.
REQ-004 SHALL have port offset  input  6  horizontal scroll column, 0..63; values 48..63 are taken as offset-48.
REQ-005 SHALL have port base_row  input  5  first store line written, 0..31.
REQ-006 SHALL have port gx  output  4  glyph column index driven to the 48x16 dot-mask ROM.
REQ-007 SHALL have port gy  output  4  glyph row index driven to the dot-mask ROM.
REQ-008 SHALL have ports pixell, pixelc, pixelr  input  1 each  ROM pixels at columns gx, 16+gx and 32+gx of row gy, valid combinationally in the same cycle.
REQ-009 SHALL have port wr_addr  output  5  store line address.
REQ-010 SHALL have port wr_data  output  32  store line data; bit 31 is the leftmost displayed pixel.
REQ-011 SHALL have port wr_valid  output  1  write request; a transfer occurs on a rising edge with wr_valid=1 and wr_ready=1.
REQ-012 SHALL have port wr_ready  input  1  store accepts the write.
REQ-013 SHALL have port busy  output  1  high from start acceptance until done.
REQ-014 SHALL have port done  output  1  single-cycle completion pulse.

Function
REQ-015 SHALL implement states IDLE, FETCH, WRITE and DONE.
REQ-016 SHALL, in IDLE with start=1, latch offset (reduced mod 48) and base_row, set row counter r=0, enter FETCH and raise busy on the same edge.
REQ-017 SHALL, in FETCH, drive gy=r and gx=0..15 over 16 consecutive cycles, capturing the three pixels each cycle into a 48-bit line register (column c = gx, 16+gx, 32+gx).
REQ-018 SHALL enter WRITE after the gx=15 cycle, driving wr_valid=1, wr_addr=(base_row+r) mod 32, and wr_data[31-j]=line[(offset+j) mod 48] for j=0..31.
REQ-019 SHALL hold wr_addr and wr_data stable, with wr_valid=1, for as long as wr_ready=0.
REQ-020 SHALL, on transfer, deassert wr_valid the next cycle and enter FETCH with r+1, or enter DONE when r=15.
REQ-021 SHALL, in DONE, assert done=1 for exactly one cycle, clear busy on the next edge, and return to IDLE.
REQ-022 SHALL ignore start while busy=1 and SHALL NOT let mid-operation changes to offset or base_row affect the current operation.
REQ-023 SHALL, with wr_ready held at 1, give row r FETCH in cycles 17r+1..17r+16 and WRITE in cycle 17r+17 (cycle 1 = first cycle after acceptance), and SHALL assert done in cycle 273.
REQ-024 SHALL, when start and done coincide, not accept start until the block is back in IDLE.
REQ-025 SHALL produce exactly 16 transfers per operation, with store addresses wrapping from 31 to 0.

Reset
REQ-026 SHALL, when reset=1 at any state, return to IDLE on that edge with busy=0, done=0, wr_valid=0, wr_addr=0, wr_data=0, gx=0 and gy=0.
REQ-027 SHALL issue no further write after reset is sampled mid-operation, and a started operation SHALL NOT resume.
REQ-028 SHALL give reset priority over start when both are high on the same edge.

Verification
REQ-029 SHALL cover this case: wr_ready=1, offset=0, base_row=0, start pulse -> 16 writes; addr1=0xFFCF033F; addr0 and addr15=0x00000000; done in cycle 273.
REQ-030 SHALL cover this case: offset=40, base_row=0 -> the row-1 write has wr_data=0xFFFFCF03, which exercises wrap across column 47.
REQ-031 SHALL cover this case: offset=50 -> treated as 2, and the row-1 write has wr_data=0xFF3C0CFF.
REQ-032 SHALL cover this case: base_row=20 -> addresses 20..31 and then 0..3 in order, with row 12 written to address 0.
REQ-033 SHALL cover this case: wr_ready=0 for 5 cycles during the row-3 WRITE -> wr_valid, wr_addr=3 and wr_data are held unchanged, and done is delayed by 5 cycles.
REQ-034 SHALL cover this case: reset in cycle 100, then start at cycle 110 -> no writes between reset and the new start, busy=0 after reset, and the new operation completes normally.
